change_dispenser: RTL

Payout side of the vending datapath. It takes a change amount in cents and drives coin-ejector solenoids as timed pulses, paying 25/10/5 greedily from tracked per-denomination inventory. It sits downstream of the vending FSM: the `change` value is presented with a `start` pulse when dispensing begins. It reports completion and any unpaid shortfall.

---
 rtl/vending_pkg.sv | 36 +++
 rtl/change_dispenser_payout_timer.sv | 37 +++
 rtl/change_dispenser.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending payout datapath.
package vending_pkg;

    localparam int unsigned AMT_W = 8;

    localparam logic [AMT_W-1:0] COIN_5  = 8'd5;
    localparam logic [AMT_W-1:0] COIN_10 = 8'd10;
    localparam logic [AMT_W-1:0] COIN_25 = 8'd25;

    // Payout states; encoded away from the vending FSM's state space.
    typedef enum logic [2:0] {
        IDLE   = 3'b100,
        SELECT = 3'b101,
        PULSE  = 3'b110,
        GAP    = 3'b111,
        FINISH = 3'b011
    } payout_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        C5   = 2'd1,
        C10  = 2'd2,
        C25  = 2'd3
    } coin_sel_e;

    // Face value in cents of a selected coin; NONE is worth nothing.
    function automatic logic [AMT_W-1:0] coin_value(input coin_sel_e sel);
        case (sel)
            C25:     return COIN_25;
            C10:     return COIN_10;
            C5:      return COIN_5;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_payout_timer.sv
// Loadable down-counter with a zero flag, shared by solenoid on and off phases.
module payout_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; the count saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin payout controller: greedy 25/10/5 change with timed solenoid pulses.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES   = 12_500_000,
    parameter int unsigned INV_WIDTH    = 8,
    parameter int unsigned INV_INIT     = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AMT_W-1:0]     amount,
    input  logic                 refill,
    output logic                 pay_25,
    output logic                 pay_10,
    output logic                 pay_5,
    output logic                 busy,
    output logic                 done,
    output logic [AMT_W-1:0]     remaining,
    output logic [AMT_W-1:0]     shortfall,
    output logic [INV_WIDTH-1:0] inv_25,
    output logic [INV_WIDTH-1:0] inv_10,
    output logic [INV_WIDTH-1:0] inv_5
);

    localparam int unsigned T_MAX   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TIMER_W-1:0]   PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [INV_WIDTH-1:0] INV_RST    = INV_WIDTH'(INV_INIT);

    payout_state_e state_q, state_d;

    logic                 pay_25_q, pay_25_d;
    logic                 pay_10_q, pay_10_d;
    logic                 pay_5_q,  pay_5_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic [AMT_W-1:0]     remaining_q, remaining_d;
    logic [AMT_W-1:0]     shortfall_q, shortfall_d;
    logic [INV_WIDTH-1:0] inv_25_q, inv_25_d;
    logic [INV_WIDTH-1:0] inv_10_q, inv_10_d;
    logic [INV_WIDTH-1:0] inv_5_q,  inv_5_d;

    coin_sel_e            pick_c;
    logic                 timer_load_c;
    logic [TIMER_W-1:0]   timer_load_val_c;
    logic                 timer_dec_c;
    logic                 timer_zero_c;

    payout_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_c),
        .load_val (timer_load_val_c),
        .dec      (timer_dec_c),
        .zero_c   (timer_zero_c)
    );

    // Greedy coin choice: largest coin that fits the balance and is in stock.
    always_comb begin
        pick_c = NONE;
        if ((remaining_q >= COIN_25) && (inv_25_q != '0)) begin
            pick_c = C25;
        end else if ((remaining_q >= COIN_10) && (inv_10_q != '0)) begin
            pick_c = C10;
        end else if ((remaining_q >= COIN_5) && (inv_5_q != '0)) begin
            pick_c = C5;
        end
    end

    // Next-state and registered-output logic for the payout sequence.
    always_comb begin
        state_d          = state_q;
        pay_25_d         = 1'b0;
        pay_10_d         = 1'b0;
        pay_5_d          = 1'b0;
        busy_d           = busy_q;
        done_d           = 1'b0;
        remaining_d      = remaining_q;
        shortfall_d      = shortfall_q;
        inv_25_d         = inv_25_q;
        inv_10_d         = inv_10_q;
        inv_5_d          = inv_5_q;
        timer_load_c     = 1'b0;
        timer_load_val_c = PULSE_LOAD;
        timer_dec_c      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // Refill lands before the first SELECT even when start coincides.
                if (refill) begin
                    inv_25_d = INV_RST;
                    inv_10_d = INV_RST;
                    inv_5_d  = INV_RST;
                end
                if (start) begin
                    remaining_d = amount;
                    shortfall_d = '0;
                    busy_d      = 1'b1;
                    state_d     = SELECT;
                end
            end

            SELECT: begin
                if (pick_c == NONE) begin
                    // Completion is flagged on entry so done and shortfall appear together.
                    done_d      = 1'b1;
                    shortfall_d = remaining_q;
                    remaining_d = '0;
                    state_d     = FINISH;
                end else begin
                    remaining_d      = remaining_q - coin_value(pick_c);
                    timer_load_c     = 1'b1;
                    timer_load_val_c = PULSE_LOAD;
                    state_d          = PULSE;
                    case (pick_c)
                        C25: begin
                            pay_25_d = 1'b1;
                            inv_25_d = inv_25_q - INV_WIDTH'(1);
                        end
                        C10: begin
                            pay_10_d = 1'b1;
                            inv_10_d = inv_10_q - INV_WIDTH'(1);
                        end
                        default: begin
                            pay_5_d = 1'b1;
                            inv_5_d = inv_5_q - INV_WIDTH'(1);
                        end
                    endcase
                end
            end

            PULSE: begin
                if (timer_zero_c) begin
                    timer_load_c     = 1'b1;
                    timer_load_val_c = GAP_LOAD;
                    state_d          = GAP;
                end else begin
                    pay_25_d    = pay_25_q;
                    pay_10_d    = pay_10_q;
                    pay_5_d     = pay_5_q;
                    timer_dec_c = 1'b1;
                end
            end

            GAP: begin
                if (timer_zero_c) begin
                    state_d = SELECT;
                end else begin
                    timer_dec_c = 1'b1;
                end
            end

            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every solenoid immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pay_25_q    <= 1'b0;
            pay_10_q    <= 1'b0;
            pay_5_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            shortfall_q <= '0;
            inv_25_q    <= INV_RST;
            inv_10_q    <= INV_RST;
            inv_5_q     <= INV_RST;
        end else begin
            state_q     <= state_d;
            pay_25_q    <= pay_25_d;
            pay_10_q    <= pay_10_d;
            pay_5_q     <= pay_5_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
            inv_25_q    <= inv_25_d;
            inv_10_q    <= inv_10_d;
            inv_5_q     <= inv_5_d;
        end
    end

    assign pay_25    = pay_25_q;
    assign pay_10    = pay_10_q;
    assign pay_5     = pay_5_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = remaining_q;
    assign shortfall = shortfall_q;
    assign inv_25    = inv_25_q;
    assign inv_10    = inv_10_q;
    assign inv_5     = inv_5_q;

endmodule
